// File: rtl/ddr5_sched_pkg.sv
// ddr5_sched_pkg: shared types and constants for the DDR5 command scheduler.
//   cmd_e    : command codes driven on cmd_code
//   op_e     : request opcodes
//   st_e     : scheduler FSM states
//   address field positions, bank-table geometry, bank_idx() helper
package ddr5_sched_pkg;

  localparam int NUM_CH    = 2;
  localparam int NUM_BG    = 8;
  localparam int NUM_BANK  = 4;
  localparam int NUM_ENTRY = NUM_CH * NUM_BG * NUM_BANK;
  localparam int IDX_W     = 6;
  localparam int ADDR_W    = 36;
  localparam int ROW_W     = 16;
  localparam int COL_W     = 6;

  localparam int CH_BIT  = 6;
  localparam int BG_LSB  = 7;
  localparam int BG_MSB  = 9;
  localparam int BA_LSB  = 10;
  localparam int BA_MSB  = 11;
  localparam int COL_LSB = 12;
  localparam int COL_MSB = 17;
  localparam int ROW_LSB = 18;
  localparam int ROW_MSB = 33;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT0, CMD_ACT1, CMD_RD0, CMD_RD1, CMD_WR0, CMD_WR1, CMD_PRE
  } cmd_e;

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_IF, OP_ILL} op_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DECODE, ST_PRE, ST_ACT0, ST_ACT1, ST_CAS0, ST_CAS1, ST_DATA, ST_AUTO_PRE
  } st_e;

  // Flat bank-table index {ch, bg, bank}.
  function automatic logic [IDX_W-1:0] bank_idx(input logic ch, input logic [2:0] bg,
                                               input logic [1:0] ba);
    return {ch, bg, ba};
  endfunction

endpackage

// File: rtl/ddr5_bank_table.sv
// ddr5_bank_table: open-row table, one {valid, row} entry per {ch, bg, bank}.
//   lk_idx/lk_row   : lookup key; hit = open at lk_row, closed = no open row
//   set_en/idx/row  : mark entry open with row (on ACT0)
//   clr_en/idx      : mark entry closed (on PRE)
//   rst_n           : async clear of the whole table
module ddr5_bank_table
  import ddr5_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [ROW_W-1:0] lk_row,
  output logic             hit,
  output logic             closed,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [ROW_W-1:0] set_row,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  logic [NUM_ENTRY-1:0]            vld;
  logic [NUM_ENTRY-1:0][ROW_W-1:0] row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      row <= '0;
    end else begin
      if (set_en) begin
        vld[set_idx] <= 1'b1;
        row[set_idx] <= set_row;
      end
      if (clr_en) vld[clr_idx] <= 1'b0;
    end
  end

  assign closed = !vld[lk_idx];
  assign hit    = vld[lk_idx] && (row[lk_idx] == lk_row);

endmodule

// File: rtl/ddr5_cmd_scheduler.sv
// ddr5_cmd_scheduler: in-order DDR5 command scheduler, one request in flight.
//   req_valid/ready/op/addr : request queue head (accepted only in IDLE)
//   cmd_valid/code/ch/bg/bank/row/col : command bus, at most one command per cycle;
//                             fields hold their last issued value while cmd_valid=0
//   done_valid/done_op      : pulse on the last data beat of a request
//   err                     : pulse when an illegal op is dropped
// Build option CLOSED_PAGE_EN: auto-precharge the bank after every access
// (closed-page). Default build keeps rows open until a conflict.
module ddr5_cmd_scheduler
  import ddr5_sched_pkg::*;
#(
  parameter int T_RCD   = 39,
  parameter int T_RP    = 39,
  parameter int T_RAS   = 76,
  parameter int T_CL    = 40,
  parameter int T_CWD   = 38,
  parameter int T_BURST = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [35:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic        cmd_ch,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [5:0]  cmd_col,
  output logic        done_valid,
  output logic [1:0]  done_op,
  output logic        err
);

  localparam logic [7:0] RAS8    = 8'(T_RAS);
  localparam logic [7:0] RP8     = 8'(T_RP);
  // Wait counters are loaded two cycles after the reference command
  // (ACT0 -> ACT1 -> first CAS0 cycle, CAS0 -> CAS1 -> first DATA cycle).
  localparam logic [7:0] RCD_LD  = 8'(T_RCD - 2);
  localparam logic [7:0] RDAT_LD = 8'(T_CL + T_BURST - 2);
  localparam logic [7:0] WDAT_LD = 8'(T_CWD + T_BURST - 2);

  st_e              state, state_nx;
  cmd_e             code;
  logic [1:0]       r_op;
  logic             r_ch, h_ch;
  logic [2:0]       r_bg, h_bg;
  logic [1:0]       r_ba, h_ba;
  logic [COL_W-1:0] r_col, h_col;
  logic [ROW_W-1:0] r_row, h_row;
  logic [7:0]       wait_cnt, cnt_act, cnt_pre;
  logic             hit, closed, ras_ok, rp_ok, wait_done, is_wr, is_ill;
  logic [IDX_W-1:0] idx;
  logic             unused_addr;

  assign unused_addr = ^{req_addr[35:34], req_addr[5:0]};

  assign idx       = bank_idx(r_ch, r_bg, r_ba);
  assign ras_ok    = cnt_act >= RAS8;
  assign rp_ok     = cnt_pre >= RP8;
  assign wait_done = wait_cnt == 8'd0;
  assign is_wr     = r_op == OP_WR;
  assign is_ill    = r_op == OP_ILL;

  ddr5_bank_table u_tbl (
    .clk     (clk),
    .rst_n   (rst_n),
    .lk_idx  (idx),
    .lk_row  (r_row),
    .hit     (hit),
    .closed  (closed),
    .set_en  (code == CMD_ACT0),
    .set_idx (idx),
    .set_row (r_row),
    .clr_en  (code == CMD_PRE),
    .clr_idx (idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (req_valid) state_nx = ST_DECODE;
      ST_DECODE: begin
        if (is_ill)      state_nx = ST_IDLE;
        else if (hit)    state_nx = ST_CAS0;
        else if (closed) state_nx = ST_ACT0;
        else             state_nx = ST_PRE;
      end
      ST_PRE:      if (ras_ok) state_nx = ST_ACT0;
      ST_ACT0:     if (rp_ok) state_nx = ST_ACT1;
      ST_ACT1:     state_nx = ST_CAS0;
      ST_CAS0:     if (wait_done) state_nx = ST_CAS1;
      ST_CAS1:     state_nx = ST_DATA;
      ST_DATA: begin
        if (wait_done) begin
`ifdef CLOSED_PAGE_EN
          state_nx = ST_AUTO_PRE;
`else
          state_nx = ST_IDLE;
`endif
        end
      end
      ST_AUTO_PRE: if (ras_ok) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    code       = CMD_NOP;
    done_valid = 1'b0;
    err        = 1'b0;
    case (state)
      ST_DECODE:          err = is_ill;
      ST_PRE, ST_AUTO_PRE: if (ras_ok) code = CMD_PRE;
      ST_ACT0:            if (rp_ok) code = CMD_ACT0;
      ST_ACT1:            code = CMD_ACT1;
      ST_CAS0:            if (wait_done) code = is_wr ? CMD_WR0 : CMD_RD0;
      ST_CAS1:            code = is_wr ? CMD_WR1 : CMD_RD1;
      ST_DATA:            done_valid = wait_done;
      default:            ;
    endcase
  end

  assign req_ready = state == ST_IDLE;
  assign cmd_valid = code != CMD_NOP;
  assign cmd_code  = code;
  assign done_op   = done_valid ? r_op : 2'b00;
  assign cmd_ch    = cmd_valid ? r_ch  : h_ch;
  assign cmd_bg    = cmd_valid ? r_bg  : h_bg;
  assign cmd_bank  = cmd_valid ? r_ba  : h_ba;
  assign cmd_row   = cmd_valid ? r_row : h_row;
  assign cmd_col   = cmd_valid ? r_col : h_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_ch     <= '0;
      r_bg     <= '0;
      r_ba     <= '0;
      r_col    <= '0;
      r_row    <= '0;
      h_ch     <= '0;
      h_bg     <= '0;
      h_ba     <= '0;
      h_col    <= '0;
      h_row    <= '0;
      wait_cnt <= '0;
      cnt_act  <= 8'hFF;
      cnt_pre  <= 8'hFF;
    end else begin
      if (req_valid && req_ready) begin
        r_op  <= req_op;
        r_ch  <= req_addr[CH_BIT];
        r_bg  <= req_addr[BG_MSB:BG_LSB];
        r_ba  <= req_addr[BA_MSB:BA_LSB];
        r_col <= req_addr[COL_MSB:COL_LSB];
        r_row <= req_addr[ROW_MSB:ROW_LSB];
      end
      case (state)
        ST_DECODE: wait_cnt <= 8'd0;
        ST_ACT1:   wait_cnt <= RCD_LD;
        ST_CAS1:   wait_cnt <= is_wr ? WDAT_LD : RDAT_LD;
        ST_CAS0, ST_DATA: if (!wait_done) wait_cnt <= wait_cnt - 8'd1;
        default:   ;
      endcase
      // Value k in cycle N means the command went out in cycle N-k; saturates.
      if (code == CMD_ACT0)      cnt_act <= 8'd1;
      else if (cnt_act != 8'hFF) cnt_act <= cnt_act + 8'd1;
      if (code == CMD_PRE)       cnt_pre <= 8'd1;
      else if (cnt_pre != 8'hFF) cnt_pre <= cnt_pre + 8'd1;
      if (cmd_valid) begin
        h_ch  <= r_ch;
        h_bg  <= r_bg;
        h_ba  <= r_ba;
        h_col <= r_col;
        h_row <= r_row;
      end
    end
  end

endmodule

// File: tb/tb_ddr5_cmd_scheduler.sv
// Directed bench for ddr5_cmd_scheduler with default timing parameters.
// Cycle numbers are relative to the accept cycle t0 (req_valid && req_ready).
module tb_ddr5_cmd_scheduler;

  localparam int T_RCD = 39, T_RP = 39, T_RAS = 76;
  localparam int RD_DONE = 40 + 8;
  localparam int WR_DONE = 38 + 8;
  localparam int C_ACT0 = 1, C_ACT1 = 2, C_RD0 = 3, C_RD1 = 4, C_WR0 = 5, C_WR1 = 6, C_PRE = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [35:0] req_addr = 36'd0;
  logic        req_ready, cmd_valid, cmd_ch, done_valid, err;
  logic [2:0]  cmd_code, cmd_bg;
  logic [1:0]  cmd_bank, done_op;
  logic [15:0] cmd_row;
  logic [5:0]  cmd_col;

  int vecs = 0, fails = 0, cyc = 0;
  int n_cmd[8] = '{default: 0};
  int c_cmd[8] = '{default: 0};
  logic [15:0] row_cmd[8];
  logic [5:0]  col_cmd[8];
  logic [2:0]  bg_cmd[8];
  logic [1:0]  ba_cmd[8];
  int n_done = 0, c_done = 0, n_err = 0, c_err = 0;
  logic [1:0] op_done = 2'd0;

  ddr5_cmd_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ch(cmd_ch), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .done_valid(done_valid), .done_op(done_op), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle.
  always @(negedge clk) begin
    if (cmd_valid) begin
      n_cmd[cmd_code]   = n_cmd[cmd_code] + 1;
      c_cmd[cmd_code]   = cyc;
      row_cmd[cmd_code] = cmd_row;
      col_cmd[cmd_code] = cmd_col;
      bg_cmd[cmd_code]  = cmd_bg;
      ba_cmd[cmd_code]  = cmd_bank;
    end
    if (done_valid) begin
      n_done  = n_done + 1;
      c_done  = cyc;
      op_done = done_op;
    end
    if (err) begin
      n_err = n_err + 1;
      c_err = cyc;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [35:0] addr, output int t0);
    int k;
    k = 0;
    while (!req_ready && k < 500) begin
      tick;
      k++;
    end
    vecs++;
    if (!req_ready) begin
      fails++;
      $display("FAIL issue_ready got 0 want 1 (timeout)");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    t0        = cyc;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int bd);
    int k;
    k = 0;
    while (n_done == bd && k < 400) begin
      tick;
      k++;
    end
    vecs++;
    if (n_done == bd) begin
      fails++;
      $display("FAIL done_timeout got no done_valid within %0d cycles", k);
    end
  endtask

  task automatic test_reset;
    repeat (2) tick;
    vecs++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", req_ready); end
    vecs++; if (cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin fails++; $display("FAIL rst_cmd got %b/%0d want 0/0", cmd_valid, cmd_code); end
    vecs++; if (done_valid !== 1'b0 || done_op !== 2'd0 || err !== 1'b0) begin fails++; $display("FAIL rst_done_err got %b/%0d/%b want 0/0/0", done_valid, done_op, err); end
    vecs++; if (cmd_row !== 16'd0 || cmd_col !== 6'd0 || cmd_bg !== 3'd0) begin fails++; $display("FAIL rst_fields got %0h/%0h/%0h want 0", cmd_row, cmd_col, cmd_bg); end
    rst_n = 1'b1;
    tick;
  endtask

  // Scenario 1: closed-bank read of address 0.
  task automatic test_closed_read;
    int t0, b[8], bd;
    b = n_cmd; bd = n_done;
    issue(2'd0, 36'h0, t0);
    wait_done(bd);
    vecs++; if (c_cmd[C_ACT0] - t0 !== 2) begin fails++; $display("FAIL s1_act0 got c%0d want c2", c_cmd[C_ACT0] - t0); end
    vecs++; if (c_cmd[C_ACT1] - t0 !== 3) begin fails++; $display("FAIL s1_act1 got c%0d want c3", c_cmd[C_ACT1] - t0); end
    vecs++; if (c_cmd[C_RD0] - t0 !== 41) begin fails++; $display("FAIL s1_rd0 got c%0d want c41", c_cmd[C_RD0] - t0); end
    vecs++; if (c_cmd[C_RD1] - t0 !== 42) begin fails++; $display("FAIL s1_rd1 got c%0d want c42", c_cmd[C_RD1] - t0); end
    vecs++; if (c_done - t0 !== 89 || op_done !== 2'd0) begin fails++; $display("FAIL s1_done got c%0d op %0d want c89 op 0", c_done - t0, op_done); end
    vecs++; if (n_cmd[C_PRE] != b[C_PRE] || n_cmd[C_WR0] != b[C_WR0]) begin fails++; $display("FAIL s1_no_pre_wr got %0d/%0d want 0/0", n_cmd[C_PRE] - b[C_PRE], n_cmd[C_WR0] - b[C_WR0]); end
    vecs++; if (req_ready !== 1'b0) begin fails++; $display("FAIL s1_ready_at_done got %b want 0", req_ready); end
    tick;
`ifdef CLOSED_PAGE_EN
    vecs++; if (n_cmd[C_PRE] - b[C_PRE] !== 1 || c_cmd[C_PRE] !== c_done + 1) begin fails++; $display("FAIL s1_auto_pre got n%0d c%0d want n1 c%0d", n_cmd[C_PRE] - b[C_PRE], c_cmd[C_PRE], c_done + 1); end
    tick;
`endif
    vecs++; if (req_ready !== 1'b1) begin fails++; $display("FAIL s1_ready_after got %b want 1", req_ready); end
  endtask

  // Scenario 2: row hit, column 5.
  task automatic test_row_hit;
    int t0, b[8], bd;
    b = n_cmd; bd = n_done;
    issue(2'd0, 36'h000005000, t0);
    wait_done(bd);
    vecs++; if (n_cmd[C_ACT0] != b[C_ACT0] || n_cmd[C_PRE] != b[C_PRE]) begin fails++; $display("FAIL s2_no_act_pre got %0d/%0d want 0/0", n_cmd[C_ACT0] - b[C_ACT0], n_cmd[C_PRE] - b[C_PRE]); end
    vecs++; if (c_cmd[C_RD0] - t0 !== 2 || col_cmd[C_RD0] !== 6'd5) begin fails++; $display("FAIL s2_rd0 got c%0d col %0d want c2 col 5", c_cmd[C_RD0] - t0, col_cmd[C_RD0]); end
    vecs++; if (c_done - c_cmd[C_RD0] !== RD_DONE) begin fails++; $display("FAIL s2_done got %0d want %0d", c_done - c_cmd[C_RD0], RD_DONE); end
  endtask

  // Scenario 3: row conflict write after a long idle (counters saturated).
  task automatic test_conflict_write;
    int t0, b[8], bd;
    repeat (300) tick;
    b = n_cmd; bd = n_done;
    issue(2'd1, 36'h000040000, t0);
    wait_done(bd);
    vecs++; if (n_cmd[C_PRE] - b[C_PRE] !== 1 || c_cmd[C_PRE] - t0 !== 2) begin fails++; $display("FAIL s3_pre got n%0d c%0d want n1 c2", n_cmd[C_PRE] - b[C_PRE], c_cmd[C_PRE] - t0); end
    vecs++; if (c_cmd[C_ACT0] - c_cmd[C_PRE] !== T_RP || row_cmd[C_ACT0] !== 16'd1) begin fails++; $display("FAIL s3_act0 got +%0d row %0d want +%0d row 1", c_cmd[C_ACT0] - c_cmd[C_PRE], row_cmd[C_ACT0], T_RP); end
    vecs++; if (c_cmd[C_WR0] - c_cmd[C_ACT0] !== T_RCD) begin fails++; $display("FAIL s3_wr0 got +%0d want +%0d", c_cmd[C_WR0] - c_cmd[C_ACT0], T_RCD); end
    vecs++; if (c_cmd[C_WR1] - c_cmd[C_WR0] !== 1 || n_cmd[C_RD0] != b[C_RD0]) begin fails++; $display("FAIL s3_wr1 got +%0d rd %0d want +1 rd 0", c_cmd[C_WR1] - c_cmd[C_WR0], n_cmd[C_RD0] - b[C_RD0]); end
    vecs++; if (c_done - c_cmd[C_WR0] !== WR_DONE || op_done !== 2'd1) begin fails++; $display("FAIL s3_done got +%0d op %0d want +%0d op 1", c_done - c_cmd[C_WR0], op_done, WR_DONE); end
    tick;
    vecs++; if (cmd_code !== 3'd0 || cmd_row !== 16'd1) begin fails++; $display("FAIL s3_hold got code %0d row %0d want 0 row 1", cmd_code, cmd_row); end
  endtask

  // Scenario 4: ifetch to closed bg=3 bank=2.
  task automatic test_ifetch;
    int t0, b[8], bd;
    b = n_cmd; bd = n_done;
    issue(2'd2, 36'h000000980, t0);
    wait_done(bd);
    vecs++; if (c_cmd[C_ACT0] - t0 !== 2 || bg_cmd[C_ACT0] !== 3'd3 || ba_cmd[C_ACT0] !== 2'd2) begin fails++; $display("FAIL s4_act0 got c%0d bg %0d ba %0d want c2 bg 3 ba 2", c_cmd[C_ACT0] - t0, bg_cmd[C_ACT0], ba_cmd[C_ACT0]); end
    vecs++; if (n_cmd[C_RD0] - b[C_RD0] !== 1 || n_cmd[C_RD1] - b[C_RD1] !== 1 || n_cmd[C_WR0] != b[C_WR0]) begin fails++; $display("FAIL s4_rd_not_wr got rd %0d wr %0d want 1/0", n_cmd[C_RD0] - b[C_RD0], n_cmd[C_WR0] - b[C_WR0]); end
    vecs++; if (c_cmd[C_RD0] - t0 !== 41 || c_done - t0 !== 89 || op_done !== 2'd2) begin fails++; $display("FAIL s4_done got rd0 c%0d done c%0d op %0d want c41 c89 op 2", c_cmd[C_RD0] - t0, c_done - t0, op_done); end
  endtask

  // Scenario 5: illegal op to a conflicting row, then a hit on the open row.
  task automatic test_illegal;
    int t0, b[8], be, bd, nb, na;
    b = n_cmd; be = n_err; bd = n_done;
    nb = 0;
    for (int i = 1; i < 8; i++) nb += b[i];
    issue(2'd3, 36'h000080000, t0);
    vecs++; if (n_err - be !== 1 || c_err - t0 !== 1) begin fails++; $display("FAIL s5_err got n%0d c%0d want n1 c1", n_err - be, c_err - t0); end
    tick;
    vecs++; if (req_ready !== 1'b1) begin fails++; $display("FAIL s5_ready got %b want 1", req_ready); end
    na = 0;
    for (int i = 1; i < 8; i++) na += n_cmd[i];
    vecs++; if (na != nb || n_done != bd) begin fails++; $display("FAIL s5_no_cmd got cmds %0d done %0d want 0/0", na - nb, n_done - bd); end
    b = n_cmd;
    issue(2'd0, 36'h000040000, t0);
    wait_done(bd);
    vecs++; if (n_cmd[C_ACT0] != b[C_ACT0] || n_cmd[C_PRE] != b[C_PRE] || c_cmd[C_RD0] - t0 !== 2) begin fails++; $display("FAIL s5_hit got act %0d pre %0d rd0 c%0d want 0/0/c2", n_cmd[C_ACT0] - b[C_ACT0], n_cmd[C_PRE] - b[C_PRE], c_cmd[C_RD0] - t0); end
  endtask

  // Scenario 6: reset at c20 of a read, then re-issue.
  task automatic test_mid_reset;
    int t0, b[8], bd;
    bd = n_done;
    issue(2'd0, 36'h0, t0);
    repeat (19) tick;
    rst_n = 1'b0;
    #1;
    vecs++; if (cyc - t0 !== 20) begin fails++; $display("FAIL s6_when got c%0d want c20", cyc - t0); end
    vecs++; if (req_ready !== 1'b1 || cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin fails++; $display("FAIL s6_outs got rdy %b v %b code %0d want 1/0/0", req_ready, cmd_valid, cmd_code); end
    vecs++; if (done_valid !== 1'b0 || err !== 1'b0 || cmd_row !== 16'd0 || cmd_col !== 6'd0) begin fails++; $display("FAIL s6_outs2 got done %b err %b row %0h col %0h want 0", done_valid, err, cmd_row, cmd_col); end
    repeat (2) tick;
    rst_n = 1'b1;
    repeat (100) tick;
    vecs++; if (n_done != bd) begin fails++; $display("FAIL s6_no_done got %0d want 0", n_done - bd); end
    b = n_cmd;
    issue(2'd0, 36'h0, t0);
    wait_done(bd);
    vecs++; if (n_cmd[C_PRE] != b[C_PRE] || c_cmd[C_ACT0] - t0 !== 2) begin fails++; $display("FAIL s6_closed got pre %0d act0 c%0d want 0 c2", n_cmd[C_PRE] - b[C_PRE], c_cmd[C_ACT0] - t0); end
    vecs++; if (c_done - t0 !== 89) begin fails++; $display("FAIL s6_done got c%0d want c89", c_done - t0); end
  endtask

`ifdef CLOSED_PAGE_EN
  // Scenario 7: previously auto-precharged bank is closed again.
  task automatic test_closed_page;
    int t0, b[8], bd, pre_c, exp_act;
    pre_c = c_cmd[C_PRE];
    b = n_cmd; bd = n_done;
    issue(2'd0, 36'h000005000, t0);
    wait_done(bd);
    exp_act = (t0 + 2 > pre_c + T_RP) ? t0 + 2 : pre_c + T_RP;
    vecs++; if (n_cmd[C_ACT0] - b[C_ACT0] !== 1 || c_cmd[C_ACT0] !== exp_act) begin fails++; $display("FAIL s7_act0 got n%0d c%0d want n1 c%0d", n_cmd[C_ACT0] - b[C_ACT0], c_cmd[C_ACT0], exp_act); end
    vecs++; if (c_cmd[C_RD0] - c_cmd[C_ACT0] !== T_RCD || col_cmd[C_RD0] !== 6'd5) begin fails++; $display("FAIL s7_rd0 got +%0d col %0d want +%0d col 5", c_cmd[C_RD0] - c_cmd[C_ACT0], col_cmd[C_RD0], T_RCD); end
    tick;
    vecs++; if (c_cmd[C_PRE] !== c_done + 1 || req_ready !== 1'b0) begin fails++; $display("FAIL s7_pre got c%0d rdy %b want c%0d rdy 0", c_cmd[C_PRE], req_ready, c_done + 1); end
    tick;
    vecs++; if (req_ready !== 1'b1) begin fails++; $display("FAIL s7_ready got %b want 1", req_ready); end
  endtask
`endif

  initial begin
    test_reset;
    test_closed_read;
`ifdef CLOSED_PAGE_EN
    test_closed_page;
`else
    test_row_hit;
    test_conflict_write;
    test_ifetch;
    test_illegal;
`endif
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
